// File: rtl/avr_io_intc_pkg.sv
// Shared definitions for the AVR I/O interrupt controller: register map,
// CTRL bit positions and arbitration FSM encoding.
package avr_io_intc_pkg;

  localparam logic [1:0] REG_PEND = 2'd0;
  localparam logic [1:0] REG_MASK = 2'd1;
  localparam logic [1:0] REG_EDGE = 2'd2;
  localparam logic [1:0] REG_CTRL = 2'd3;

  localparam int CTRL_GIE_BIT  = 0;
  localparam int CTRL_VECT_LSB = 4;
  localparam int CTRL_BUSY_BIT = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2
  } intc_state_e;

endpackage

// File: rtl/avr_io_intc_if.sv
// Core-side I/O register bus of the interrupt controller (4-register window).
interface avr_io_intc_if;
  logic       io_re;
  logic       io_we;
  logic [1:0] io_a;
  logic [7:0] io_di;
  logic [7:0] io_do;

  modport master (output io_re, io_we, io_a, io_do, input io_di);
  modport slave  (input io_re, io_we, io_a, io_do, output io_di);
endinterface

// File: rtl/avr_io_intc_prio.sv
// Combinational fixed-priority encoder: lowest set index wins.
module avr_intc_prio #(
  parameter int N_IRQ  = 8,
  parameter int VECT_W = 3
) (
  input  logic [N_IRQ-1:0]  req,
  output logic              valid,
  output logic [VECT_W-1:0] idx
);

  // Scan from the top down so the lowest requesting index is written last.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    valid = 1'b0;
    idx   = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        idx   = VECT_W'(i);
      end
    end
  end

endmodule

// File: rtl/avr_io_intc.sv
// AVR-style I/O interrupt controller: PEND/MASK/EDGE/CTRL registers, edge
// latches, fixed-priority arbitration and an IDLE->REQ->HOLD vector handshake.
module avr_io_intc
  import avr_io_intc_pkg::*;
#(
  parameter int N_IRQ  = 8,
  parameter int VECT_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  avr_io_intc_if.slave      bus,
  input  logic [N_IRQ-1:0]  irq,
  output logic              iflag,
  output logic [VECT_W-1:0] ivect,
  input  logic              ieack,
  output logic [N_IRQ-1:0]  irq_ack
);

  intc_state_e       state, state_next;
  logic [N_IRQ-1:0]  mask_r, edge_sel_r, lat_r, irq_q;
  logic              gie_r;
  logic [VECT_W-1:0] ivect_r;
  logic              load_vect;

  logic [N_IRQ-1:0]  rise, pend, eligible, w1c, vect_oh;
  logic              arb_valid, frozen_ok, busy;
  logic [VECT_W-1:0] arb_idx;
  logic              wr_pend, wr_mask, wr_edge, wr_ctrl;
  logic [7:0]        rdata;

  assign wr_pend = bus.io_we && (bus.io_a == REG_PEND);
  assign wr_mask = bus.io_we && (bus.io_a == REG_MASK);
  assign wr_edge = bus.io_we && (bus.io_a == REG_EDGE);
  assign wr_ctrl = bus.io_we && (bus.io_a == REG_CTRL);

  assign w1c       = wr_pend ? bus.io_do[N_IRQ-1:0] : '0;
  assign rise      = irq & ~irq_q;
  assign pend      = (lat_r & edge_sel_r) | (irq & ~edge_sel_r);
  assign eligible  = gie_r ? (pend & mask_r) : '0;
  assign vect_oh   = N_IRQ'(1) << ivect_r;
  assign frozen_ok = |(eligible & vect_oh);
  assign busy      = (state != ST_IDLE);
  assign iflag     = (state == ST_REQ);
  assign ivect     = ivect_r;

  avr_intc_prio #(.N_IRQ(N_IRQ), .VECT_W(VECT_W)) u_prio (
    .req   (eligible),
    .valid (arb_valid),
    .idx   (arb_idx)
  );

  // Configuration registers written from the core.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask_r     <= '0;
      edge_sel_r <= '0;
      gie_r      <= 1'b0;
    end else begin
      // NOTE: sequential state always uses non-blocking assignment so every flop samples pre-edge values.
      if (wr_mask) mask_r     <= bus.io_do[N_IRQ-1:0];
      if (wr_edge) edge_sel_r <= bus.io_do[N_IRQ-1:0];
      if (wr_ctrl) gie_r      <= bus.io_do[CTRL_GIE_BIT];
    end
  end

  // Edge detector and edge latches; a new rising edge beats a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_q <= '0;
      lat_r <= '0;
    end else begin
      irq_q <= irq;
      lat_r <= (lat_r & ~(w1c | irq_ack)) | (rise & edge_sel_r);
    end
  end

  // FSM state and the vector frozen at arbitration time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      ivect_r <= '0;
    end else begin
      state <= state_next;
      if (load_vect) ivect_r <= arb_idx;
    end
  end

  // Next-state and acknowledge logic; ieack outranks retraction in REQ.
  always_comb begin
    state_next = state;
    load_vect  = 1'b0;
    irq_ack    = '0;
    case (state)
      ST_IDLE: begin
        if (arb_valid) begin
          state_next = ST_REQ;
          load_vect  = 1'b1;
        end
      end
      ST_REQ: begin
        if (ieack) begin
          irq_ack    = vect_oh;
          state_next = ST_HOLD;
        end else if (!frozen_ok) begin
          state_next = ST_IDLE;
        end
      end
      ST_HOLD: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Read mux onto the wired-OR bus: all zeros unless this block is read.
  always_comb begin
    rdata = '0;
    if (bus.io_re) begin
      case (bus.io_a)
        REG_PEND: rdata[N_IRQ-1:0] = pend;
        REG_MASK: rdata[N_IRQ-1:0] = mask_r;
        REG_EDGE: rdata[N_IRQ-1:0] = edge_sel_r;
        REG_CTRL: begin
          rdata[CTRL_GIE_BIT]                = gie_r;
          rdata[CTRL_BUSY_BIT]               = busy;
          rdata[CTRL_VECT_LSB +: VECT_W]     = ivect_r;
        end
        default: rdata = '0;
      endcase
    end
  end

  assign bus.io_di = rdata;

endmodule

// File: doc/avr_io_intc.md
AVR_IO_INTC -- requirements
Module: avr_io_intc

Interface
REQ-001 SHALL have parameter N_IRQ, default 8: number of interrupt sources, fixed range 1..8.
REQ-002 SHALL have parameter VECT_W, default 3: ivect width; 2**VECT_W >= N_IRQ.
REQ-003 SHALL have port clk  in  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port io_re  in  1  read strobe, pre-qualified by the block's 4-register I/O select.
REQ-006 SHALL have port io_we  in  1  write strobe, pre-qualified by the I/O select.
REQ-007 SHALL have port io_a  in  2  register index.
REQ-008 SHALL have port io_di  out  8  read data to core; 8'h00 whenever io_re=0 (wired-OR bus).
REQ-009 SHALL have port io_do  in  8  write data from core.
REQ-010 SHALL have port irq  in  N_IRQ  raw interrupt requests, synchronous to clk.
REQ-011 SHALL have port iflag  out  1  interrupt request to core.
REQ-012 SHALL have port ivect  out  VECT_W  vector index presented with iflag.
REQ-013 SHALL have port ieack  in  1  one-cycle pulse from core: presented vector taken.
REQ-014 SHALL have port irq_ack  out  N_IRQ  one-hot, one-cycle acknowledge to the serviced source.

Function
REQ-015 SHALL decode registers: 0 PEND (R; W1C), 1 MASK (RW), 2 EDGE (RW; 1=rising-edge source, 0=level), 3 CTRL (bit0 GIE RW; bit7 busy R; bits[VECT_W+3:4] ivect R).
REQ-016 SHALL return PEND = (edge latch & EDGE) | (irq & ~EDGE) on a read.
REQ-017 SHALL return reads combinationally in the io_re cycle; unimplemented bits read 0.
REQ-018 SHALL set an edge latch on irq rising (irq & ~irq_q) for EDGE sources; irq_q resets to 0.
REQ-019 SHALL clear an edge latch on W1C to PEND, or on ieack when that source is the presented vector.
REQ-020 SHALL let set win over clear when a rising edge and a clear hit the same latch in the same cycle.
REQ-021 SHALL form eligible = PEND & MASK, gated by GIE; priority is fixed, lowest index highest.
REQ-022 SHALL implement FSM IDLE -> REQ -> HOLD -> IDLE.
REQ-023 SHALL in IDLE drive iflag=0; with eligible!=0, latch highest-priority index into ivect and enter REQ next cycle (1-cycle latency).
REQ-024 SHALL in REQ drive iflag=1 with ivect frozen; a higher-priority arrival does not change ivect.
REQ-025 SHALL in REQ on ieack pulse irq_ack[ivect] for exactly one cycle (same cycle as the ieack edge) and enter HOLD.
REQ-026 SHALL in REQ without ieack return to IDLE (retract, iflag=0) when the frozen source leaves eligible (masked, cleared, level dropped, GIE=0).
REQ-027 SHALL when REQ sees ieack and retraction in the same cycle treat ieack as taking priority.
REQ-028 SHALL stay in HOLD exactly one cycle with iflag=0, then go to IDLE, so a level source can deassert before re-arbitration.
REQ-029 SHALL ignore ieack in IDLE and HOLD; no irq_ack is produced.
REQ-030 SHALL report CTRL.busy=1 in REQ and HOLD.

Reset
REQ-031 SHALL on rst force: FSM IDLE; iflag=0; ivect=0; irq_ack=0; MASK=0; EDGE=0; GIE=0; edge latches=0; irq_q=0.
REQ-032 SHALL on rst asserted mid-REQ drop iflag immediately (asynchronous) and discard the pending acknowledge.

Structure
REQ-033 SHALL keep register indices, CTRL bit positions and FSM state encodings in a shared package/include file.
REQ-034 SHALL use one sub-module avr_intc_prio: combinational N_IRQ-bit fixed-priority encoder giving valid and index.

Verification
REQ-035 SHALL pass: MASK=8'h04, GIE=1, irq[2] level high -> iflag=1, ivect=2 two cycles later; ieack -> irq_ack=8'h04 for one cycle, then iflag=0 for one HOLD cycle.
REQ-036 SHALL pass: EDGE=8'h01, MASK=8'h01, one-cycle pulse on irq[0] -> PEND reads 8'h01; ieack clears it; PEND reads 8'h00.
REQ-037 SHALL pass: in REQ with ivect=5, irq[1] rises -> ivect stays 5 until ieack; next arbitration presents ivect=1.
REQ-038 SHALL pass: in REQ with ivect=3, write MASK=8'h00 -> iflag=0 next cycle; a later ieack gives irq_ack=0.
REQ-039 SHALL pass: write PEND=8'h01 in the same cycle as a new irq[0] rising edge (EDGE[0]=1) -> latch stays 1.
REQ-040 SHALL pass: assert rst during REQ -> iflag=0 at once, MASK, EDGE and CTRL read 8'h00 after release.
